// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if
// Bundles the signals between the LEGv8 multicycle control unit and the datapath.
// The control unit is the master: it reads the fetched opcode and the data-memory
// completion flag, and it drives every datapath control input.
//   op          : IM_readData[31:21], valid while the controller is in FETCH
//   dm_ready    : data memory finished its access this cycle
//   reg2loc, AluSrc, memtoReg, AluControl : datapath mux and ALU selects
//   Branch, memRead, memWrite, regWrite   : datapath strobes
//   pc_en, instr_done : PC update enable and its identical retire pulse
//   exc         : sticky exception code (00 none, 01 illegal, 10 memory timeout)
//   state       : current controller state (FETCH=0 .. HALT=5)
interface multicycle_ctrl_if;
   logic [10:0] op;
   logic        dm_ready;
   logic        reg2loc;
   logic        AluSrc;
   logic        memtoReg;
   logic [3:0]  AluControl;
   logic        Branch;
   logic        memRead;
   logic        memWrite;
   logic        regWrite;
   logic        pc_en;
   logic        instr_done;
   logic [1:0]  exc;
   logic [2:0]  state;

   // Controller side
   modport master (
      input  op, dm_ready,
      output reg2loc, AluSrc, memtoReg, AluControl,
      output Branch, memRead, memWrite, regWrite,
      output pc_en, instr_done, exc, state
   );

   // Datapath side
   modport slave (
      output op, dm_ready,
      input  reg2loc, AluSrc, memtoReg, AluControl,
      input  Branch, memRead, memWrite, regWrite,
      input  pc_en, instr_done, exc, state
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
// Multicycle control unit for the LEGv8 64-bit datapath. Each instruction walks
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB); illegal opcodes and data-memory
// timeouts park the unit in HALT until reset.
//   TIMEOUT : MEM cycles allowed without dm_ready before a bus-error exception
//   clk     : single clock, rising edge
//   reset   : synchronous, active-low
//   bus     : multicycle_ctrl_if.master, opcode/dm_ready in, all controls out
module multicycle_ctrl #(
   parameter int TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             reset,
   multicycle_ctrl_if.master bus
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      HALT   = 3'd5
   } state_t;

   typedef enum logic [2:0] {
      CL_ILL   = 3'd0,
      CL_LDUR  = 3'd1,
      CL_STUR  = 3'd2,
      CL_CBZ   = 3'd3,
      CL_RTYPE = 3'd4
   } class_t;

   // Maps an opcode onto its instruction class; CBZ ignores the low 3 opcode bits.
   function automatic class_t classify(input logic [10:0] o);
      class_t c;
      c = CL_ILL;
      if (o == 11'b11111000010)
         c = CL_LDUR;
      else if (o == 11'b11111000000)
         c = CL_STUR;
      else if (o[10:3] == 8'b10110100)
         c = CL_CBZ;
      else if ((o == 11'b10001011000) || (o == 11'b11001011000) ||
               (o == 11'b10001010000) || (o == 11'b10101010000))
         c = CL_RTYPE;
      return c;
   endfunction

   // Mux selects for an opcode, packed as {reg2loc, AluSrc, memtoReg, AluControl}.
   // Illegal opcodes yield all zeros.
   function automatic logic [6:0] decodeSels(input logic [10:0] o);
      logic [6:0] s;
      s = 7'b0;
      case (classify(o))
         CL_LDUR:  s = 7'b0_1_1_0010;
         CL_STUR:  s = 7'b1_1_0_0010;
         CL_CBZ:   s = 7'b1_0_0_0111;
         CL_RTYPE: begin
            if (o == 11'b10001011000)
               s = 7'b0_0_0_0010;
            else if (o == 11'b11001011000)
               s = 7'b0_0_0_0110;
            else if (o == 11'b10001010000)
               s = 7'b0_0_0_0000;
            else
               s = 7'b0_0_0_0001;
         end
         default:  s = 7'b0;
      endcase
      return s;
   endfunction

   state_t        r_state;
   logic [10:0]   r_opQ;
   logic [CW-1:0] r_waitCount;
   logic [1:0]    r_exc;
   logic [6:0]    r_sels;

   class_t        w_qClass;
   logic          w_memRead;
   logic          w_memWrite;
   logic          w_regWrite;
   logic          w_branch;
   logic          w_pcEn;

   assign w_qClass = classify(r_opQ);

   // Main state machine. The mux selects are registered here: loaded from the
   // opcode on the FETCH->DECODE edge (the same value that lands in r_opQ) and
   // cleared on every edge that returns to FETCH or enters HALT, so they stay
   // steady for the whole instruction.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state     <= FETCH;
         r_opQ       <= 11'b0;
         r_waitCount <= '0;
         r_exc       <= 2'b00;
         r_sels      <= 7'b0;
      end else begin
         case (r_state)
            FETCH: begin
               r_opQ   <= bus.op;
               r_sels  <= decodeSels(bus.op);
               r_state <= DECODE;
            end
            DECODE: begin
               if (w_qClass == CL_ILL) begin
                  r_state <= HALT;
                  r_exc   <= 2'b01;
                  r_sels  <= 7'b0;
               end else begin
                  r_state <= EXEC;
               end
            end
            EXEC: begin
               if (w_qClass == CL_CBZ) begin
                  r_state <= FETCH;
                  r_sels  <= 7'b0;
               end else if ((w_qClass == CL_LDUR) || (w_qClass == CL_STUR)) begin
                  r_state     <= MEM;
                  r_waitCount <= '0;
               end else begin
                  r_state <= WB;
               end
            end
            MEM: begin
               // dm_ready takes priority over an expiring wait count.
               if (bus.dm_ready) begin
                  if (w_qClass == CL_LDUR) begin
                     r_state <= WB;
                  end else begin
                     r_state <= FETCH;
                     r_sels  <= 7'b0;
                  end
               end else if (r_waitCount == LAST_WAIT) begin
                  r_state <= HALT;
                  r_exc   <= 2'b10;
                  r_sels  <= 7'b0;
               end else begin
                  r_waitCount <= r_waitCount + CW'(1);
               end
            end
            WB: begin
               r_state <= FETCH;
               r_sels  <= 7'b0;
            end
            HALT: begin
               r_state <= HALT;
            end
            default: begin
               r_state <= FETCH;
               r_sels  <= 7'b0;
            end
         endcase
      end
   end

   // Strobes are decoded from state and the latched opcode. They are gated by
   // reset so nothing is written to memory, the register file or the PC in the
   // cycle before the state register clears.
   always_comb begin
      w_memRead  = 1'b0;
      w_memWrite = 1'b0;
      w_regWrite = 1'b0;
      w_branch   = 1'b0;
      w_pcEn     = 1'b0;
      if (reset) begin
         case (r_state)
            EXEC: begin
               w_branch = (w_qClass == CL_CBZ);
               w_pcEn   = (w_qClass == CL_CBZ);
            end
            MEM: begin
               w_memRead  = (w_qClass == CL_LDUR);
               w_memWrite = (w_qClass == CL_STUR);
               w_pcEn     = (w_qClass == CL_STUR) && bus.dm_ready;
            end
            WB: begin
               w_regWrite = 1'b1;
               w_pcEn     = 1'b1;
            end
            default: begin
               w_pcEn = 1'b0;
            end
         endcase
      end
   end

   assign bus.reg2loc    = r_sels[6];
   assign bus.AluSrc     = r_sels[5];
   assign bus.memtoReg   = r_sels[4];
   assign bus.AluControl = r_sels[3:0];
   assign bus.memRead    = w_memRead;
   assign bus.memWrite   = w_memWrite;
   assign bus.regWrite   = w_regWrite;
   assign bus.Branch     = w_branch;
   assign bus.pc_en      = w_pcEn;
   assign bus.instr_done = w_pcEn;
   assign bus.exc        = r_exc;
   assign bus.state      = r_state;

endmodule
